// File: rtl/ip_bus_initiator.sv
// Single-command bus master for the MSX-50BUS memory interface: turns valid/ready
// commands into level read/write strobes and returns one response per command.
module ip_bus_initiator #(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned WRITE_HOLD = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_address,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_write_data,
    output logic        bus_memory_read,
    output logic        bus_memory_write,
    input  logic        bus_read_ready,
    input  logic [7:0]  bus_read_data
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(WRITE_HOLD - 1);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_READ_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE_HOLD = 2'd2;
    localparam logic [1:0] ST_RECOVER    = 2'd3;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] counter, counter_nx;
    logic [15:0]      address_nx;
    logic [7:0]       write_data_nx;
    logic             memory_read_nx, memory_write_nx;
    logic             rsp_valid_nx, rsp_timeout_nx;
    logic [7:0]       rsp_rdata_nx;

    // Accepting commands depends on state alone so the source sees a stable ready.
    assign cmd_ready = (state == ST_IDLE);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state            <= ST_IDLE;
            counter          <= '0;
            bus_address      <= 16'h0000;
            bus_write_data   <= 8'h00;
            bus_memory_read  <= 1'b0;
            bus_memory_write <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= 8'h00;
            rsp_timeout      <= 1'b0;
        end else begin
            state            <= state_nx;
            counter          <= counter_nx;
            bus_address      <= address_nx;
            bus_write_data   <= write_data_nx;
            bus_memory_read  <= memory_read_nx;
            bus_memory_write <= memory_write_nx;
            rsp_valid        <= rsp_valid_nx;
            rsp_rdata        <= rsp_rdata_nx;
            rsp_timeout      <= rsp_timeout_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx        = state;
        counter_nx      = counter;
        address_nx      = bus_address;
        write_data_nx   = bus_write_data;
        memory_read_nx  = bus_memory_read;
        memory_write_nx = bus_memory_write;
        rsp_valid_nx    = 1'b0;
        rsp_rdata_nx    = rsp_rdata;
        rsp_timeout_nx  = rsp_timeout;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    address_nx = cmd_address;
                    counter_nx = '0;
                    if (cmd_write) begin
                        write_data_nx   = cmd_wdata;
                        memory_write_nx = 1'b1;
                        state_nx        = ST_WRITE_HOLD;
                    end else begin
                        memory_read_nx = 1'b1;
                        state_nx       = ST_READ_WAIT;
                    end
                end
            end
            ST_READ_WAIT: begin
                // A ready on the final sampling edge still beats the timeout.
                if (bus_read_ready) begin
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = bus_read_data;
                    rsp_timeout_nx = 1'b0;
                    memory_read_nx = 1'b0;
                    state_nx       = ST_RECOVER;
                end else if (counter == TIMEOUT_LAST) begin
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = 8'hFF;
                    rsp_timeout_nx = 1'b1;
                    memory_read_nx = 1'b0;
                    state_nx       = ST_RECOVER;
                end else begin
                    counter_nx = counter + CNT_W'(1);
                end
            end
            ST_WRITE_HOLD: begin
                if (counter == HOLD_LAST) begin
                    memory_write_nx = 1'b0;
                    rsp_valid_nx    = 1'b1;
                    rsp_rdata_nx    = 8'h00;
                    rsp_timeout_nx  = 1'b0;
                    state_nx        = ST_RECOVER;
                end else begin
                    counter_nx = counter + CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ip_bus_initiator.sv
// Scoreboard bench for ip_bus_initiator with a zero-wait RAM target at 0x8000-0xBFFF
// and a programmable slow device at 0xC000.
module tb_ip_bus_initiator;

    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned WRITE_HOLD = 2;

    logic        clk;
    logic        n_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_address;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [15:0] bus_address;
    logic [7:0]  bus_write_data;
    logic        bus_memory_read;
    logic        bus_memory_write;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;

    ip_bus_initiator #(.TIMEOUT(TIMEOUT), .WRITE_HOLD(WRITE_HOLD)) dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_address      (cmd_address),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_timeout      (rsp_timeout),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_memory_read  (bus_memory_read),
        .bus_memory_write (bus_memory_write),
        .bus_read_ready   (bus_read_ready),
        .bus_read_data    (bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        logic       to;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rd_rises = 0;
    int   wr_run = 0;
    int   wr_pulses = 0;
    logic prev_rd_n = 1'b0;

    logic [7:0] ram [0:16383];
    logic       prev_wr;
    int         rd_age;
    int         slow_edge;
    logic       tgt_ready;
    logic [7:0] tgt_data;
    logic       stray_ready;

    assign bus_read_ready = tgt_ready | stray_ready;
    assign bus_read_data  = tgt_data | (stray_ready ? 8'h77 : 8'h00);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Target models: RAM answers on the 2nd sampling edge, 0xC000 on slow_edge.
    always @(posedge clk) begin
        prev_wr <= bus_memory_write;
        if (!n_reset) begin
            ram[0] <= 8'h11;
            ram[1] <= 8'h22;
            ram[2] <= 8'h33;
        end else if (bus_memory_write && !prev_wr && bus_address[15:14] == 2'b10) begin
            ram[bus_address[13:0]] <= bus_write_data;
        end
        rd_age    <= bus_memory_read ? rd_age + 1 : 0;
        tgt_ready <= 1'b0;
        tgt_data  <= 8'h00;
        if (bus_memory_read) begin
            if (bus_address[15:14] == 2'b10 && rd_age + 1 == 1) begin
                tgt_ready <= 1'b1;
                tgt_data  <= ram[bus_address[13:0]];
            end else if (bus_address == 16'hC000 && rd_age + 1 == slow_edge - 1) begin
                tgt_ready <= 1'b1;
                tgt_data  <= 8'h3C;
            end
        end
    end

    // Cycle count and accept-edge log (value recorded is the cycle just after the edge).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!n_reset) acc_q.delete();
        else if (cmd_valid && cmd_ready) acc_q.push_back(cyc + 1);
    end

    // Output monitor and scoreboard pop
    always @(negedge clk) begin
        if (n_reset) begin
            check("cmd_ready", 32'(cmd_ready), 32'(acc_q.size() == 0));
            if (bus_memory_read && bus_memory_write) check("strobe_overlap", 1, 0);
            if (bus_memory_read && !prev_rd_n) rd_rises++;
            if (bus_memory_write) wr_run++;
            else if (wr_run != 0) begin
                check("wr_width", 32'(wr_run), 32'(WRITE_HOLD));
                wr_pulses++;
                wr_run = 0;
            end
            if (rsp_valid) begin
                check("rsp_strobes", 32'({bus_memory_read, bus_memory_write}), 0);
                if (exp_q.size() == 0) check("unexp_rsp", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    if (acc_q.size() == 0) check("rsp_no_accept", 1, 0);
                    else check("rsp_latency", 32'(cyc - acc_q.pop_front()), 32'(e.lat));
                end
            end
        end
        prev_rd_n = bus_memory_read;
    end

    task automatic send(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                        input logic want_rsp, input logic [7:0] ex_rd, input logic ex_to,
                        input int ex_lat, input logic hold);
        int n;
        if (want_rsp) exp_q.push_back('{ex_rd, ex_to, ex_lat});
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = addr;
        cmd_wdata   = wd;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 1);
        check({tag, "_strobes"}, 32'({bus_memory_read, bus_memory_write}), 0);
        check({tag, "_addr"}, 32'(bus_address), 0);
        check({tag, "_wdata"}, 32'(bus_write_data), 0);
        check({tag, "_rsp"}, 32'({rsp_valid, rsp_timeout}), 0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_reset     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_address = 16'h0000;
        cmd_wdata   = 8'h00;
        slow_edge   = 0;
        stray_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_reset = 1'b1;
        @(negedge clk);

        send(1'b1, 16'h8123, 8'h5A, 1'b1, 8'h00, 1'b0, int'(WRITE_HOLD), 1'b0);
        drain();
        send(1'b0, 16'h8123, 8'h00, 1'b1, 8'h5A, 1'b0, 2, 1'b0);
        drain();

        send(1'b0, 16'h0000, 8'h00, 1'b1, 8'hFF, 1'b1, int'(TIMEOUT), 1'b0);
        drain();

        slow_edge = 16;
        send(1'b0, 16'hC000, 8'h00, 1'b1, 8'h3C, 1'b0, 16, 1'b0);
        drain();
        slow_edge = 17;
        send(1'b0, 16'hC000, 8'h00, 1'b1, 8'hFF, 1'b1, int'(TIMEOUT), 1'b0);
        drain();
        repeat (4) @(negedge clk);

        // Back-to-back reads with cmd_valid held across commands.
        send(1'b0, 16'h8000, 8'h00, 1'b1, 8'h11, 1'b0, 2, 1'b1);
        send(1'b0, 16'h8001, 8'h00, 1'b1, 8'h22, 1'b0, 2, 1'b1);
        send(1'b0, 16'h8002, 8'h00, 1'b1, 8'h33, 1'b0, 2, 1'b0);
        drain();

        // Reset in the middle of a slow read: no response may follow.
        slow_edge = 40;
        send(1'b0, 16'hC000, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        send(1'b0, 16'h8123, 8'h00, 1'b1, 8'h5A, 1'b0, 2, 1'b0);
        drain();

        // Stray ready while idle
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_rsp", 32'(rsp_valid), 0);
            check("stray_idle", 32'(cmd_ready), 1);
        end

        check("read_strobe_count", 32'(rd_rises), 9);
        check("write_strobe_count", 32'(wr_pulses), 1);
        check("leftover_exp", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
